// File: rtl/kmbox_proto_pkg.sv
// Bridge <-> KMBox UART protocol constants and state encodings.
// Shared by the bridge sender and the KMBox responder.
package kmbox_proto_pkg;

  localparam logic [7:0] SYNC       = 8'hBD;
  localparam logic [7:0] CMD_MOVE   = 8'h01;
  localparam logic [7:0] CMD_BUTTON = 8'h02;
  localparam logic [7:0] CMD_PING   = 8'hFE;

  localparam int LEN_MOVE   = 2;
  localparam int LEN_BUTTON = 1;
  localparam int LEN_PING   = 0;

  typedef enum logic [1:0] {
    P_IDLE,
    P_GOT_SYNC,
    P_PAY0,
    P_PAY1
  } parse_st_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_WAIT,
    TX_CMD,
    TX_DONE
  } tx_st_e;

  // Payload length of a command; -1 marks an unknown code.
  function automatic int pay_len(input logic [7:0] cmd);
    int len;
    len = -1;
    if (cmd == CMD_MOVE)   len = LEN_MOVE;
    if (cmd == CMD_BUTTON) len = LEN_BUTTON;
    if (cmd == CMD_PING)   len = LEN_PING;
    return len;
  endfunction

endpackage

// File: rtl/kmbox_reply_tx.sv
// PING reply sequencer: emits SYNC then CMD_PING, one byte per
// tx_ready window, with a guard cycle after each byte.
module kmbox_reply_tx
  import kmbox_proto_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       tx_ready,
  output logic       busy,
  output logic       tx_valid,
  output logic [7:0] tx_data
);

  tx_st_e st_q, st_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= TX_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      TX_IDLE: if (req)      st_d = TX_SYNC;
      TX_SYNC: if (tx_ready) st_d = TX_WAIT;
      TX_WAIT:               st_d = TX_CMD;
      TX_CMD:  if (tx_ready) st_d = TX_DONE;
      TX_DONE:               st_d = TX_IDLE;
      default:               st_d = TX_IDLE;
    endcase
  end

  always_comb begin
    busy     = (st_q != TX_IDLE);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (st_q == TX_SYNC && tx_ready) begin
      tx_valid = 1'b1;
      tx_data  = SYNC;
    end
    if (st_q == TX_CMD && tx_ready) begin
      tx_valid = 1'b1;
      tx_data  = CMD_PING;
    end
  end

endmodule

// File: rtl/kmbox_cmd_responder.sv
// KMBox-side frame parser: MOVE/BUTTON strobes, PING echo,
// link liveness and a saturating protocol error counter.
module kmbox_cmd_responder
  import kmbox_proto_pkg::*;
#(
  parameter int CLK_FREQ     = 48_000_000,
  parameter int BYTE_TIMEOUT = CLK_FREQ / 1000,
  parameter int PING_TIMEOUT = CLK_FREQ * 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       move_valid,
  output logic [7:0] move_dx,
  output logic [7:0] move_dy,
  output logic       btn_valid,
  output logic [7:0] btn_state,
  output logic       link_alive,
  output logic [7:0] err_count
);

  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int PW = $clog2(PING_TIMEOUT + 1);
  localparam logic [BW-1:0] BT_LAST = BW'(BYTE_TIMEOUT - 1);
  localparam logic [PW-1:0] PT_MAX  = PW'(PING_TIMEOUT);

  parse_st_e st_q, st_d;
  logic [7:0]    cmd_q, cmd_d, dx_q, dx_d;
  logic          mv_q, mv_d, bv_q, bv_d;
  logic [7:0]    mdx_q, mdx_d, mdy_q, mdy_d;
  logic [7:0]    btn_q, btn_d, err_q, err_d;
  logic          alive_q, alive_d, req_q, req_d;
  logic [BW-1:0] btmr_q, btmr_d;
  logic [PW-1:0] ptmr_q, ptmr_d;

  logic in_sync, ping_fire, cmd_err, move_fire, btn_fire;
  logic byte_exp, drop, busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= P_IDLE;
      cmd_q   <= 8'h00;
      dx_q    <= 8'h00;
      mv_q    <= 1'b0;
      bv_q    <= 1'b0;
      mdx_q   <= 8'h00;
      mdy_q   <= 8'h00;
      btn_q   <= 8'h00;
      err_q   <= 8'h00;
      alive_q <= 1'b0;
      req_q   <= 1'b0;
      btmr_q  <= '0;
      ptmr_q  <= '0;
    end else begin
      st_q    <= st_d;
      cmd_q   <= cmd_d;
      dx_q    <= dx_d;
      mv_q    <= mv_d;
      bv_q    <= bv_d;
      mdx_q   <= mdx_d;
      mdy_q   <= mdy_d;
      btn_q   <= btn_d;
      err_q   <= err_d;
      alive_q <= alive_d;
      req_q   <= req_d;
      btmr_q  <= btmr_d;
      ptmr_q  <= ptmr_d;
    end
  end

  // A byte landing in the expiry cycle takes priority over the timeout.
  always_comb begin
    st_d = st_q;
    if (rx_valid) begin
      unique case (st_q)
        P_IDLE:
          if (rx_data == SYNC) st_d = P_GOT_SYNC;
        P_GOT_SYNC:
          if (rx_data == SYNC)          st_d = P_GOT_SYNC;
          else if (pay_len(rx_data) > 0) st_d = P_PAY0;
          else                          st_d = P_IDLE;
        P_PAY0:
          st_d = (pay_len(cmd_q) > 1) ? P_PAY1 : P_IDLE;
        P_PAY1:
          st_d = P_IDLE;
        default:
          st_d = P_IDLE;
      endcase
    end else if (byte_exp) begin
      st_d = P_IDLE;
    end
  end

  always_comb begin
    in_sync   = rx_valid && (st_q == P_GOT_SYNC);
    ping_fire = in_sync && (rx_data == CMD_PING);
    cmd_err   = in_sync && (rx_data != SYNC)
                && (pay_len(rx_data) < 0);
    move_fire = rx_valid && (st_q == P_PAY1);
    btn_fire  = rx_valid && (st_q == P_PAY0)
                && (cmd_q == CMD_BUTTON);
    byte_exp  = !rx_valid && (st_q != P_IDLE)
                && (btmr_q == BT_LAST);
    drop      = req_q && busy;

    cmd_d = cmd_q;
    if (in_sync && pay_len(rx_data) > 0) cmd_d = rx_data;
    dx_d = dx_q;
    if (rx_valid && st_q == P_PAY0 && cmd_q == CMD_MOVE)
      dx_d = rx_data;

    mv_d  = move_fire;
    mdx_d = move_fire ? dx_q : mdx_q;
    mdy_d = move_fire ? rx_data : mdy_q;
    bv_d  = btn_fire;
    btn_d = btn_fire ? rx_data : btn_q;

    if (rx_valid || byte_exp || st_q == P_IDLE) btmr_d = '0;
    else                                       btmr_d = btmr_q + 1'b1;

    if (ping_fire)            ptmr_d = '0;
    else if (ptmr_q == PT_MAX) ptmr_d = ptmr_q;
    else                      ptmr_d = ptmr_q + 1'b1;

    if (ping_fire)            alive_d = 1'b1;
    else if (ptmr_d == PT_MAX) alive_d = 1'b0;
    else                      alive_d = alive_q;

    req_d = ping_fire;

    err_d = err_q;
    if ((cmd_err || byte_exp || drop) && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  kmbox_reply_tx u_reply (
    .clk      (clk),
    .rst      (rst),
    .req      (req_q),
    .tx_ready (tx_ready),
    .busy     (busy),
    .tx_valid (tx_valid),
    .tx_data  (tx_data)
  );

  assign move_valid = mv_q;
  assign move_dx    = mdx_q;
  assign move_dy    = mdy_q;
  assign btn_valid  = bv_q;
  assign btn_state  = btn_q;
  assign link_alive = alive_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_kmbox_cmd_responder.sv
// Bench for kmbox_cmd_responder: directed protocol cases plus a
// randomized byte stream scored against a frame-level model.
module tb_kmbox_cmd_responder;

  localparam int BT = 20;
  localparam int PT = 300;
  localparam logic [7:0] BD = 8'hBD;
  localparam logic [7:0] FE = 8'hFE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data, move_dx, move_dy, btn_state, err_count;
  logic       tx_valid, move_valid, btn_valid, link_alive;

  kmbox_cmd_responder #(
    .BYTE_TIMEOUT (BT),
    .PING_TIMEOUT (PT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .move_valid (move_valid),
    .move_dx    (move_dx),
    .move_dy    (move_dy),
    .btn_valid  (btn_valid),
    .btn_state  (btn_state),
    .link_alive (link_alive),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output recorder
  logic [15:0] mv_log[$];
  int          mv_cyc[$];
  logic [7:0]  bt_log[$];
  int          bt_cyc[$];
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];
  int          b2b = 0;
  logic        tx_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      tx_prev <= 1'b0;
    end else begin
      if (move_valid) begin
        mv_log.push_back({move_dx, move_dy});
        mv_cyc.push_back(cyc);
      end
      if (btn_valid) begin
        bt_log.push_back(btn_state);
        bt_cyc.push_back(cyc);
      end
      if (tx_valid) begin
        tx_log.push_back(tx_data);
        tx_cyc.push_back(cyc);
      end
      if (tx_valid && tx_prev) b2b <= b2b + 1;
      tx_prev <= tx_valid;
    end
  end

  function automatic logic [7:0] txb(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction
  function automatic int txc(input int i);
    return (i < tx_cyc.size()) ? tx_cyc[i] : -1;
  endfunction
  function automatic logic [15:0] mvb(input int i);
    return (i < mv_log.size()) ? mv_log[i] : 16'hxxxx;
  endfunction
  function automatic int mvc(input int i);
    return (i < mv_cyc.size()) ? mv_cyc[i] : -1;
  endfunction
  function automatic logic [7:0] btb(input int i);
    return (i < bt_log.size()) ? bt_log[i] : 8'hxx;
  endfunction
  function automatic int btc(input int i);
    return (i < bt_cyc.size()) ? bt_cyc[i] : -1;
  endfunction

  // Reference model: frames accumulated as a byte list
  logic [7:0]  fb[$];
  int          m_err = 0;
  bit          has_ping = 0;
  int          ping_cyc = 0;
  int          busy_end = -1000;
  bit          la_chk = 0;
  logic [15:0] e_mv[$];
  int          e_mv_cyc[$];
  logic [7:0]  e_bt[$];
  int          e_bt_cyc[$];
  logic [7:0]  e_tx[$];
  int          e_tx_cyc[$];

  function automatic void m_err_inc();
    if (m_err < 255) m_err++;
  endfunction

  function automatic logic exp_alive();
    return has_ping && (cyc - ping_cyc >= 1) && (cyc - ping_cyc <= PT);
  endfunction

  task automatic m_byte(input logic [7:0] b, input int gap);
    int n;
    n = cyc;
    if (fb.size() > 0 && gap >= BT) begin
      m_err_inc();
      fb.delete();
    end
    if (fb.size() == 0) begin
      if (b == BD) fb.push_back(b);
    end else if (fb.size() == 1) begin
      if (b == 8'h01 || b == 8'h02) begin
        fb.push_back(b);
      end else if (b == FE) begin
        fb.delete();
        has_ping = 1;
        ping_cyc = n;
        // reply occupies the sequencer from n+2 up to n+5
        if (n + 1 <= busy_end) m_err_inc();
        else begin
          busy_end = n + 5;
          e_tx.push_back(BD);
          e_tx_cyc.push_back(n + 2);
          e_tx.push_back(FE);
          e_tx_cyc.push_back(n + 4);
        end
      end else if (b != BD) begin
        m_err_inc();
        fb.delete();
      end
    end else begin
      fb.push_back(b);
      if (fb[1] == 8'h02) begin
        e_bt.push_back(fb[2]);
        e_bt_cyc.push_back(n + 1);
        fb.delete();
      end else if (fb.size() == 4) begin
        e_mv.push_back({fb[2], fb[3]});
        e_mv_cyc.push_back(n + 1);
        fb.delete();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (la_chk) check("alive", link_alive, exp_alive());
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_data  = b;
    rx_valid = 1'b1;
    m_byte(b, gap);
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    la_chk   = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    fb.delete();
    e_mv.delete();
    e_mv_cyc.delete();
    e_bt.delete();
    e_bt_cyc.delete();
    e_tx.delete();
    e_tx_cyc.delete();
    m_err    = 0;
    has_ping = 0;
    busy_end = -1000;
    repeat (3) step();
    rst = 1'b0;
    step();
    la_chk = 1;
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return BT + $urandom_range(0, 2);
    if (r == 1) return BT - 1;
    return $urandom_range(0, 3);
  endfunction

  logic [7:0] f[$];
  logic [7:0] r8;
  int n, tb0, mb, bb;

  initial begin
    do_reset();
    check("reset_outs", {tx_valid, tx_data, move_valid, move_dx,
                         move_dy, btn_valid, btn_state, link_alive,
                         err_count}, 64'd0);

    // PING echo
    tb0 = tx_log.size();
    send(BD, 0);
    n = cyc;
    send(FE, 0);
    check("ping_alive", link_alive, 1);
    repeat (10) step();
    check("ping_ntx", tx_log.size() - tb0, 2);
    check("ping_tx0", {txc(tb0) - n, txb(tb0)}, {32'd2, BD});
    check("ping_tx1", {txc(tb0 + 1) - n, txb(tb0 + 1)}, {32'd4, FE});
    check("ping_err", err_count, 0);

    // MOVE with SYNC value as payload
    mb = mv_log.size();
    send(BD, 0);
    send(8'h01, 0);
    send(BD, 0);
    n = cyc;
    send(8'h05, 0);
    check("mv_pulse", move_valid, 1);
    check("mv_data", {move_dx, move_dy}, 16'hBD05);
    step();
    check("mv_single", move_valid, 0);
    repeat (3) step();
    check("mv_count", mv_log.size() - mb, 1);
    check("mv_cyc", mvc(mb) - n, 1);
    check("mv_hold", {move_dx, move_dy}, 16'hBD05);
    check("mv_err", err_count, 0);

    // Resync on repeated SYNC
    bb = bt_log.size();
    send(8'h00, 0);
    send(BD, 0);
    send(BD, 0);
    send(8'h02, 0);
    n = cyc;
    send(8'h81, 0);
    check("btn_pulse", {btn_valid, btn_state}, 9'h181);
    repeat (3) step();
    check("btn_log", {btc(bb) - n, btb(bb), bt_log.size() - bb},
          {32'd1, 8'h81, 32'd1});
    check("btn_err", err_count, 0);

    // Bad command, then byte timeout
    send(BD, 0);
    send(8'h33, 0);
    repeat (3) step();
    check("badcmd_err", err_count, 1);
    mb = mv_log.size();
    send(BD, 0);
    send(8'h01, 0);
    send(8'h7F, 0);
    repeat (BT - 1) step();
    check("to_before", err_count, 1);
    step();
    check("to_after", err_count, 2);
    repeat (3) step();
    check("to_nomove", mv_log.size() - mb, 0);

    // Byte on the expiry cycle wins
    send(BD, 0);
    send(8'h01, 0);
    send(8'h7F, 0);
    send(8'h22, BT - 1);
    check("exp_move", {move_valid, move_dx, move_dy}, 17'h17F22);
    repeat (3) step();
    check("exp_err", err_count, 2);

    // Reply overlap while UART busy
    tx_ready = 1'b0;
    tb0 = tx_log.size();
    send(BD, 0);
    send(FE, 0);
    send(BD, 0);
    send(FE, 0);
    repeat (4) step();
    check("ovl_err", err_count, 3);
    check("ovl_held", tx_log.size() - tb0, 0);
    tx_ready = 1'b1;
    repeat (8) step();
    check("ovl_ntx", tx_log.size() - tb0, 2);
    check("ovl_bytes", {txb(tb0), txb(tb0 + 1)}, {BD, FE});
    for (int i = 0; i < 300; i++) begin
      tx_ready = 1'b0;
      send(BD, 0);
      send(FE, 0);
      send(BD, 0);
      send(FE, 0);
      tx_ready = 1'b1;
      repeat (8) step();
    end
    check("sat_err", err_count, 8'hFF);
    tx_ready = 1'b0;
    send(BD, 0);
    send(FE, 0);
    send(BD, 0);
    send(FE, 0);
    tx_ready = 1'b1;
    repeat (8) step();
    check("sat_hold", err_count, 8'hFF);

    // Liveness window
    send(BD, 0);
    send(FE, 0);
    repeat (PT - 1) step();
    check("alive_last", link_alive, 1);
    step();
    check("alive_drop", link_alive, 0);
    repeat (5) step();

    // Reset between reply bytes
    tb0 = tx_log.size();
    send(BD, 0);
    send(FE, 0);
    step();
    check("rst_bd", {tx_valid, tx_data}, {1'b1, BD});
    step();
    la_chk = 0;
    rst = 1'b1;
    #1;
    check("rst_async", {tx_valid, tx_data, move_valid, move_dx,
                        move_dy, btn_valid, btn_state, link_alive,
                        err_count}, 64'd0);
    do_reset();
    repeat (8) step();
    check("rst_no_fe", tx_log.size() - tb0, 1);
    check("rst_outs", {tx_valid, tx_data, move_valid, move_dx,
                       move_dy, btn_valid, btn_state, link_alive,
                       err_count}, 64'd0);

    // Randomized stream against the model
    mb  = mv_log.size();
    bb  = bt_log.size();
    tb0 = tx_log.size();
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: f = '{BD, 8'h01, 8'($urandom), 8'($urandom)};
        1: f = '{BD, 8'h02, 8'($urandom)};
        2: f = '{BD, FE};
        3: begin
          r8 = 8'($urandom);
          if (r8 == 8'h01 || r8 == 8'h02 || r8 == FE || r8 == BD)
            r8 = 8'h33;
          f = '{BD, r8};
        end
        4: f = '{8'($urandom)};
        default: f = '{BD, BD, 8'h02, 8'($urandom)};
      endcase
      for (int i = 0; i < f.size(); i++) send(f[i], rgap());
    end
    repeat (BT + 10) step();
    if (fb.size() > 0) begin
      m_err_inc();
      fb.delete();
    end
    check("rnd_err", err_count, m_err);
    check("rnd_nmv", mv_log.size() - mb, e_mv.size());
    check("rnd_nbt", bt_log.size() - bb, e_bt.size());
    check("rnd_ntx", tx_log.size() - tb0, e_tx.size());
    for (int i = 0; i < e_mv.size(); i++)
      check("rnd_mv", {mvc(mb + i), mvb(mb + i)},
            {e_mv_cyc[i], e_mv[i]});
    for (int i = 0; i < e_bt.size(); i++)
      check("rnd_bt", {btc(bb + i), btb(bb + i)},
            {e_bt_cyc[i], e_bt[i]});
    for (int i = 0; i < e_tx.size(); i++)
      check("rnd_tx", {txc(tb0 + i), txb(tb0 + i)},
            {e_tx_cyc[i], e_tx[i]});
    check("tx_b2b", b2b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
